// File: rtl/ysyx_22051468_wb_sched_if.sv
// Bundle between the issue stage, EXU/LSU result ports, the GPR write port and the
// write-back scheduler. The scheduler takes the slave modport.
interface ysyx_22051468_wb_sched_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 6
);
  localparam int unsigned RIDX_W = $clog2(NREG);

  logic              iss_valid;
  logic [RIDX_W-1:0] iss_rd;
  logic              iss_rd_we;
  logic [RIDX_W-1:0] iss_rs1;
  logic [RIDX_W-1:0] iss_rs2;
  logic              iss_ready;

  logic              exu_valid;
  logic [RIDX_W-1:0] exu_rd;
  logic [WIDTH-1:0]  exu_data;
  logic              exu_ready;

  logic              lsu_valid;
  logic [RIDX_W-1:0] lsu_rd;
  logic [WIDTH-1:0]  lsu_data;
  logic              lsu_ready;

  logic [RIDX_W-1:0] rd_waddr_o;
  logic [WIDTH-1:0]  rd_wdata_o;
  logic              wen_o;
  logic [NREG-1:0]   busy_o;
  logic [CNT_W-1:0]  pend_cnt_o;

  modport slave (
    input  iss_valid, iss_rd, iss_rd_we, iss_rs1, iss_rs2,
    input  exu_valid, exu_rd, exu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output iss_ready, exu_ready, lsu_ready,
    output rd_waddr_o, rd_wdata_o, wen_o, busy_o, pend_cnt_o
  );

  modport master (
    output iss_valid, iss_rd, iss_rd_we, iss_rs1, iss_rs2,
    output exu_valid, exu_rd, exu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  iss_ready, exu_ready, lsu_ready,
    input  rd_waddr_o, rd_wdata_o, wen_o, busy_o, pend_cnt_o
  );
endinterface

// File: rtl/ysyx_22051468_wb_sched.sv
// Write-back scheduler: round-robin share of the GPR write port between EXU and LSU,
// plus a per-register scoreboard that stalls issue on RAW/WAW hazards.
module ysyx_22051468_wb_sched #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic                        clk,
  input logic                        rst_n,
  ysyx_22051468_wb_sched_if.slave    bus
);
  localparam int unsigned RIDX_W = $clog2(NREG);

  typedef enum logic {
    PRI_LSU = 1'b0,
    PRI_EXU = 1'b1
  } pri_e;

  pri_e              pri_q, pri_d;
  logic              exu_rdy_c, lsu_rdy_c;
  logic              exu_xfer_c, lsu_xfer_c;

  logic              wen_q, wen_d;
  logic [RIDX_W-1:0] waddr_q, waddr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [CNT_W-1:0]  pend_q, pend_d;

  logic [NREG-1:0]   set_vec_c, clr_vec_c, hz_vec_c;
  logic              iss_ready_c, iss_set_c;

  // Priority pointer state register
  always_ff @(posedge clk) begin
    if (!rst_n) pri_q <= PRI_LSU;
    else        pri_q <= pri_d;
  end

  // Pointer moves to the loser only when both requesters compete
  always_comb begin
    pri_d = pri_q;
    if (bus.exu_valid && bus.lsu_valid)
      pri_d = (pri_q == PRI_LSU) ? PRI_EXU : PRI_LSU;
  end

  // Grant outputs: a requester is ready unless the other one is valid and favoured
  always_comb begin
    exu_rdy_c = !bus.lsu_valid || (pri_q == PRI_EXU);
    lsu_rdy_c = !bus.exu_valid || (pri_q == PRI_LSU);
  end

  assign exu_xfer_c    = bus.exu_valid && exu_rdy_c;
  assign lsu_xfer_c    = bus.lsu_valid && lsu_rdy_c;
  assign bus.exu_ready = exu_rdy_c;
  assign bus.lsu_ready = lsu_rdy_c;

  // Capture the winning transfer; x0 targets take the slot but never write
  always_comb begin
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (lsu_xfer_c) begin
      waddr_d = bus.lsu_rd;
      wdata_d = bus.lsu_data;
      wen_d   = (bus.lsu_rd != '0);
    end else if (exu_xfer_c) begin
      waddr_d = bus.exu_rd;
      wdata_d = bus.exu_data;
      wen_d   = (bus.exu_rd != '0);
    end
  end

  // The in-flight write is excluded from hazards since the GPR file forwards it
  always_comb begin
    clr_vec_c = '0;
    if (wen_q) clr_vec_c[waddr_q] = 1'b1;
    hz_vec_c    = busy_q & ~clr_vec_c;
    iss_ready_c = !(hz_vec_c[bus.iss_rs1] || hz_vec_c[bus.iss_rs2] ||
                    (bus.iss_rd_we && hz_vec_c[bus.iss_rd]));
    iss_set_c   = bus.iss_valid && iss_ready_c && bus.iss_rd_we && (bus.iss_rd != '0);
    set_vec_c   = '0;
    if (iss_set_c) set_vec_c[bus.iss_rd] = 1'b1;
  end

  // Scoreboard update; set overrides a same-index clear
  always_comb begin
    busy_d    = (busy_q & ~clr_vec_c) | set_vec_c;
    busy_d[0] = 1'b0;
    pend_d    = pend_q;
    if (iss_set_c && !wen_q)      pend_d = pend_q + CNT_W'(1);
    else if (wen_q && !iss_set_c) pend_d = pend_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
      pend_q  <= '0;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.iss_ready  = iss_ready_c;
  assign bus.wen_o      = wen_q;
  assign bus.rd_waddr_o = waddr_q;
  assign bus.rd_wdata_o = wdata_q;
  assign bus.busy_o     = busy_q;
  assign bus.pend_cnt_o = pend_q;
endmodule

// File: tb/tb_ysyx_22051468_wb_sched.sv
// Directed bench for the write-back scheduler: reset, single writes, contention,
// RAW/WAW hazards, x0 handling and mid-operation reset.
module tb_ysyx_22051468_wb_sched;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ysyx_22051468_wb_sched_if #(.WIDTH(64), .NREG(32), .CNT_W(6)) bus ();

  ysyx_22051468_wb_sched #(.WIDTH(64), .NREG(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.iss_valid = 1'b1;
    bus.iss_rd    = rd;
    bus.iss_rd_we = 1'b1;
    bus.iss_rs1   = 5'd0;
    bus.iss_rs2   = 5'd0;
  endtask

  task automatic no_issue();
    bus.iss_valid = 1'b0;
    bus.iss_rd_we = 1'b0;
    bus.iss_rd    = 5'd0;
  endtask

  // Requesters must only retire registers that the scoreboard marks busy
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.exu_valid && bus.exu_ready && bus.exu_rd != 5'd0) begin
        checks++;
        assert (bus.busy_o[bus.exu_rd] === 1'b1) else begin
          errors++;
          $error("FAIL protocol_exu rd=%0d busy=0x%0h expected busy bit set", bus.exu_rd, bus.busy_o);
        end
      end
      if (bus.lsu_valid && bus.lsu_ready && bus.lsu_rd != 5'd0) begin
        checks++;
        assert (bus.busy_o[bus.lsu_rd] === 1'b1) else begin
          errors++;
          $error("FAIL protocol_lsu rd=%0d busy=0x%0h expected busy bit set", bus.lsu_rd, bus.busy_o);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0; bus.iss_rd_we = 1'b0;
    bus.iss_rs1 = '0; bus.iss_rs2 = '0;
    bus.exu_valid = 1'b0; bus.exu_rd = '0; bus.exu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    settle();

    // Reset then idle
    chk("rst_busy",  64'(bus.busy_o), 64'h0);
    chk("rst_pend",  64'(bus.pend_cnt_o), 64'h0);
    chk("rst_wen",   64'(bus.wen_o), 64'h0);
    chk("rst_waddr", 64'(bus.rd_waddr_o), 64'h0);
    chk("rst_wdata", 64'(bus.rd_wdata_o), 64'h0);
    chk("rst_iss_ready", 64'(bus.iss_ready), 64'h1);
    chk("rst_exu_ready", 64'(bus.exu_ready), 64'h1);
    chk("rst_lsu_ready", 64'(bus.lsu_ready), 64'h1);

    // Single EXU write to x5
    bus.iss_rs1 = 5'd1; bus.iss_rs2 = 5'd2;
    issue(5'd5); bus.iss_rs1 = 5'd1; bus.iss_rs2 = 5'd2;
    settle();
    chk("ex_iss_ready", 64'(bus.iss_ready), 64'h1);
    tick();
    no_issue();
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd5; bus.exu_data = 64'hDEAD;
    settle();
    chk("ex_busy_set", 64'(bus.busy_o), 64'h20);
    chk("ex_pend_1",   64'(bus.pend_cnt_o), 64'h1);
    chk("ex_exu_ready", 64'(bus.exu_ready), 64'h1);
    tick();
    bus.exu_valid = 1'b0;
    bus.iss_rs1 = 5'd5;
    settle();
    chk("ex_wen",   64'(bus.wen_o), 64'h1);
    chk("ex_waddr", 64'(bus.rd_waddr_o), 64'h5);
    chk("ex_wdata", 64'(bus.rd_wdata_o), 64'hDEAD);
    chk("ex_busy_hold", 64'(bus.busy_o), 64'h20);
    chk("ex_fwd_iss_ready", 64'(bus.iss_ready), 64'h1);
    tick();
    bus.iss_rs1 = 5'd0; bus.iss_rs2 = 5'd0;
    settle();
    chk("ex_busy_clr", 64'(bus.busy_o), 64'h0);
    chk("ex_pend_0",   64'(bus.pend_cnt_o), 64'h0);
    chk("ex_wen_low",  64'(bus.wen_o), 64'h0);

    // Contention round 1: pointer starts at LSU
    issue(5'd3); tick();
    issue(5'd4); tick();
    no_issue();
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd3; bus.exu_data = 64'h33;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 64'h44;
    settle();
    chk("c1_busy", 64'(bus.busy_o), 64'h18);
    chk("c1_pend", 64'(bus.pend_cnt_o), 64'h2);
    chk("c1_lsu_ready", 64'(bus.lsu_ready), 64'h1);
    chk("c1_exu_ready", 64'(bus.exu_ready), 64'h0);
    tick();
    bus.lsu_valid = 1'b0;
    settle();
    chk("c1_waddr_lsu", 64'(bus.rd_waddr_o), 64'h4);
    chk("c1_wdata_lsu", 64'(bus.rd_wdata_o), 64'h44);
    chk("c1_wen_lsu",   64'(bus.wen_o), 64'h1);
    chk("c1_exu_ready2", 64'(bus.exu_ready), 64'h1);
    tick();
    bus.exu_valid = 1'b0;
    settle();
    chk("c1_waddr_exu", 64'(bus.rd_waddr_o), 64'h3);
    chk("c1_wdata_exu", 64'(bus.rd_wdata_o), 64'h33);
    chk("c1_busy_mid",  64'(bus.busy_o), 64'h08);
    chk("c1_pend_mid",  64'(bus.pend_cnt_o), 64'h1);
    tick();
    chk("c1_busy_end",  64'(bus.busy_o), 64'h0);
    chk("c1_pend_end",  64'(bus.pend_cnt_o), 64'h0);

    // Contention round 2: EXU now favoured
    issue(5'd3); tick();
    issue(5'd4); tick();
    no_issue();
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd3; bus.exu_data = 64'h3A;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 64'h4A;
    settle();
    chk("c2_exu_ready", 64'(bus.exu_ready), 64'h1);
    chk("c2_lsu_ready", 64'(bus.lsu_ready), 64'h0);
    tick();
    bus.exu_valid = 1'b0;
    settle();
    chk("c2_waddr_exu", 64'(bus.rd_waddr_o), 64'h3);
    chk("c2_wdata_exu", 64'(bus.rd_wdata_o), 64'h3A);
    chk("c2_lsu_ready2", 64'(bus.lsu_ready), 64'h1);
    tick();
    bus.lsu_valid = 1'b0;
    settle();
    chk("c2_waddr_lsu", 64'(bus.rd_waddr_o), 64'h4);
    chk("c2_wdata_lsu", 64'(bus.rd_wdata_o), 64'h4A);
    chk("c2_busy_mid",  64'(bus.busy_o), 64'h10);
    tick();
    chk("c2_busy_end",  64'(bus.busy_o), 64'h0);
    chk("c2_pend_end",  64'(bus.pend_cnt_o), 64'h0);

    // RAW stall on x7
    issue(5'd7); tick();
    no_issue(); bus.iss_rs1 = 5'd7;
    settle();
    chk("raw_busy",  64'(bus.busy_o), 64'h80);
    chk("raw_stall0", 64'(bus.iss_ready), 64'h0);
    tick();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 64'h77;
    settle();
    chk("raw_stall1", 64'(bus.iss_ready), 64'h0);
    chk("raw_lsu_ready", 64'(bus.lsu_ready), 64'h1);
    tick();
    bus.lsu_valid = 1'b0;
    settle();
    chk("raw_wen",  64'(bus.wen_o), 64'h1);
    chk("raw_waddr", 64'(bus.rd_waddr_o), 64'h7);
    chk("raw_release", 64'(bus.iss_ready), 64'h1);
    tick();
    bus.iss_rs1 = 5'd0;
    settle();
    chk("raw_busy_clr", 64'(bus.busy_o), 64'h0);

    // WAW with same-cycle set and clear on x9
    issue(5'd9); tick();
    no_issue();
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd9; bus.exu_data = 64'h99;
    tick();
    bus.exu_valid = 1'b0;
    issue(5'd9);
    settle();
    chk("waw_wen",   64'(bus.wen_o), 64'h1);
    chk("waw_waddr", 64'(bus.rd_waddr_o), 64'h9);
    chk("waw_iss_ready", 64'(bus.iss_ready), 64'h1);
    chk("waw_pend_pre", 64'(bus.pend_cnt_o), 64'h1);
    tick();
    no_issue();
    settle();
    chk("waw_busy_keep", 64'(bus.busy_o), 64'h200);
    chk("waw_pend_keep", 64'(bus.pend_cnt_o), 64'h1);
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd9; bus.exu_data = 64'h98;
    tick();
    bus.exu_valid = 1'b0;
    settle();
    chk("waw_wdata2", 64'(bus.rd_wdata_o), 64'h98);
    tick();
    chk("waw_busy_clr", 64'(bus.busy_o), 64'h0);
    chk("waw_pend_clr", 64'(bus.pend_cnt_o), 64'h0);

    // x0 handling
    issue(5'd0);
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 64'h1234;
    settle();
    chk("x0_iss_ready", 64'(bus.iss_ready), 64'h1);
    chk("x0_lsu_ready", 64'(bus.lsu_ready), 64'h1);
    tick();
    no_issue();
    bus.lsu_valid = 1'b0;
    settle();
    chk("x0_wen",  64'(bus.wen_o), 64'h0);
    chk("x0_busy", 64'(bus.busy_o), 64'h0);
    chk("x0_pend", 64'(bus.pend_cnt_o), 64'h0);

    // Reset mid-operation: leave pointer at EXU and a write in flight
    issue(5'd10); tick();
    issue(5'd11); tick();
    no_issue();
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd10; bus.exu_data = 64'hA0;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd11; bus.lsu_data = 64'hB0;
    settle();
    chk("mr_lsu_wins", 64'(bus.lsu_ready), 64'h1);
    tick();
    bus.exu_valid = 1'b0; bus.lsu_valid = 1'b0;
    rst_n = 1'b0;
    settle();
    chk("mr_wen_inflight", 64'(bus.wen_o), 64'h1);
    tick();
    rst_n = 1'b1;
    settle();
    chk("mr_wen",   64'(bus.wen_o), 64'h0);
    chk("mr_waddr", 64'(bus.rd_waddr_o), 64'h0);
    chk("mr_wdata", 64'(bus.rd_wdata_o), 64'h0);
    chk("mr_busy",  64'(bus.busy_o), 64'h0);
    chk("mr_pend",  64'(bus.pend_cnt_o), 64'h0);
    issue(5'd10); tick();
    issue(5'd11); tick();
    no_issue();
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd10; bus.exu_data = 64'hA1;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd11; bus.lsu_data = 64'hB1;
    settle();
    chk("mr_ptr_lsu", 64'(bus.lsu_ready), 64'h1);
    chk("mr_ptr_exu", 64'(bus.exu_ready), 64'h0);
    tick();
    bus.lsu_valid = 1'b0;
    tick();
    bus.exu_valid = 1'b0;
    settle();
    chk("mr_final_waddr", 64'(bus.rd_waddr_o), 64'hA);
    tick();
    chk("mr_final_busy", 64'(bus.busy_o), 64'h0);
    chk("mr_final_pend", 64'(bus.pend_cnt_o), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
